// File: rtl/mat_pkg.sv
// mat_pkg: shared state type, default element geometry and sizing helpers for the tile loader.
package mat_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COLS = 128;
  function automatic int calc_wpt(input int tile_rows, input int rows_per_word);
    return tile_rows / rows_per_word;
  endfunction
  function automatic int calc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mat_rd_lat_pipe.sv
// mat_rd_lat_pipe: RD_LAT-deep valid/word-index tag shift register with synchronous flush.
module mat_rd_lat_pipe #(
  parameter int RD_LAT = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [RD_LAT-1:0] vld_q;
  logic [IDX_W-1:0] idx_q [RD_LAT];
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end
  assign vld_o = vld_q[RD_LAT-1];
  assign idx_o = idx_q[RD_LAT-1];
endmodule

// File: rtl/mat_tile_loader.sv
// mat_tile_loader: fetches one tile of packed rows from a synchronous-read memory into a registered matrix.
// Define MAT_TILE_LOADER_CLR_EN to zero the whole matrix on every accepted request.
module mat_tile_loader
  import mat_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COLS = DEF_COLS,
  parameter int ROWS_PER_WORD = 4,
  parameter int TILE_ROWS = 16,
  parameter int NUM_TILES = 64,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2,
  localparam int SEL_W = calc_w(NUM_TILES),
  localparam int WORD_W = ROWS_PER_WORD * COLS * DATA_W
) (
  input  logic                                       I_CLK,
  input  logic                                       I_RST,
  input  logic                                       I_VLD_PULSE,
  input  logic [SEL_W-1:0]                           I_SEL,
  output logic                                       O_RD_EN,
  output logic [ADDR_W-1:0]                          O_ADDR,
  input  logic [WORD_W-1:0]                          I_RDATA,
  output logic                                       O_BUSY,
  output logic                                       O_VLD,
  output logic                                       O_ERR,
  output logic [0:TILE_ROWS-1][0:COLS-1][DATA_W-1:0] O_MAT
);
  localparam int WPT = calc_wpt(TILE_ROWS, ROWS_PER_WORD);
  localparam int IDX_W = calc_w(WPT);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(WPT - 1);
  localparam logic [SEL_W:0] SEL_LIM = (SEL_W + 1)'(NUM_TILES);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] k_q, k_d, tag_idx;
  logic err_q, tag_vld, accept, reject;
  logic [0:TILE_ROWS-1][0:COLS-1][DATA_W-1:0] mat_q;
  assign accept = I_VLD_PULSE && ({1'b0, I_SEL} < SEL_LIM);
  assign reject = I_VLD_PULSE && !accept;
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= S_IDLE;
      base_q <= '0;
      k_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      k_q <= k_d;
      err_q <= reject;
    end
  end
  always_comb begin
    state_d = accept ? S_ISSUE
            : (state_q == S_ISSUE && k_q == K_LAST) ? S_DRAIN
            : (state_q == S_DRAIN && tag_vld && tag_idx == K_LAST) ? S_DONE
            : state_q;
    base_d = accept ? ADDR_W'(I_SEL) * ADDR_W'(WPT) : base_q;
    k_d = accept ? '0 : (state_q == S_ISSUE && k_q != K_LAST) ? k_q + 1'b1 : k_q;
  end
  always_comb begin
    O_RD_EN = state_q == S_ISSUE;
    O_BUSY = state_q == S_ISSUE || state_q == S_DRAIN;
    O_VLD = state_q == S_DONE;
    O_ERR = err_q;
    O_ADDR = base_q + ADDR_W'(k_q);
  end
  // Flushing on accept drops every tag of an aborted fetch, including the read issued on the accepting edge.
  mat_rd_lat_pipe #(.RD_LAT(RD_LAT), .IDX_W(IDX_W)) u_pipe (
    .clk_i  (I_CLK),
    .rst_i  (I_RST),
    .flush_i(accept),
    .vld_i  (O_RD_EN),
    .idx_i  (k_q),
    .vld_o  (tag_vld),
    .idx_o  (tag_idx)
  );
  always_ff @(posedge I_CLK) begin
    if (I_RST) mat_q <= '0;
`ifdef MAT_TILE_LOADER_CLR_EN
    else if (accept) mat_q <= '0;
`else
    else if (accept) mat_q <= mat_q;
`endif
    else if (tag_vld)
      for (int x = 0; x < ROWS_PER_WORD; x++)
        for (int y = 0; y < COLS; y++)
          mat_q[int'(tag_idx) * ROWS_PER_WORD + x][y] <= I_RDATA[(x * COLS + y) * DATA_W +: DATA_W];
  end
  assign O_MAT = mat_q;
endmodule

// File: tb/tb_mat_tile_loader.sv
// tb_mat_tile_loader: directed checks of fetch, restart, reject, reset and latency variants.
module tb_mat_tile_loader;
  logic clk = 1'b0;
  logic rst, vld_a, vld_b;
  logic [5:0] sel_a, sel_b;
  logic rd_a, rd_b, busy_a, busy_b, ok_a, ok_b, err_a, err_b;
  logic [7:0] addr_a, addr_b;
  logic [4095:0] rdata_a, rdata_b;
  logic [0:15][0:127][7:0] mat_a;
  logic [0:7][0:127][7:0] mat_b;
  logic [7:0] pipe_a [2];
  logic [7:0] pipe_b [4];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  function automatic logic [4095:0] mk_word(input logic [7:0] a);
    logic [4095:0] w;
    for (int j = 0; j < 512; j++) w[j*8 +: 8] = 8'(j) ^ a;
    return w;
  endfunction
  function automatic logic [7:0] exp_el(input int t, input int wpt, input int r, input int y);
    logic [7:0] a;
    a = 8'(t * wpt + r / 4);
    return 8'((r % 4) * 128 + y) ^ a;
  endfunction
  function automatic int bad_a(input int t);
    int n = 0;
    for (int r = 0; r < 16; r++) for (int y = 0; y < 128; y++) if (mat_a[r][y] !== exp_el(t, 4, r, y)) n++;
    return n;
  endfunction
  function automatic int bad_b(input int t);
    int n = 0;
    for (int r = 0; r < 8; r++) for (int y = 0; y < 128; y++) if (mat_b[r][y] !== exp_el(t, 2, r, y)) n++;
    return n;
  endfunction
  function automatic int nonzero_a();
    int n = 0;
    for (int r = 0; r < 16; r++) for (int y = 0; y < 128; y++) if (mat_a[r][y] !== 8'd0) n++;
    return n;
  endfunction
  always @(posedge clk) begin
    pipe_a[0] <= addr_a;
    pipe_a[1] <= pipe_a[0];
    pipe_b[0] <= addr_b;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign rdata_a = mk_word(pipe_a[1]);
  assign rdata_b = mk_word(pipe_b[3]);
  mat_tile_loader dut_a (
    .I_CLK(clk), .I_RST(rst), .I_VLD_PULSE(vld_a), .I_SEL(sel_a), .O_RD_EN(rd_a), .O_ADDR(addr_a),
    .I_RDATA(rdata_a), .O_BUSY(busy_a), .O_VLD(ok_a), .O_ERR(err_a), .O_MAT(mat_a)
  );
  mat_tile_loader #(.TILE_ROWS(8), .NUM_TILES(48), .RD_LAT(4)) dut_b (
    .I_CLK(clk), .I_RST(rst), .I_VLD_PULSE(vld_b), .I_SEL(sel_b), .O_RD_EN(rd_b), .O_ADDR(addr_b),
    .I_RDATA(rdata_b), .O_BUSY(busy_b), .O_VLD(ok_b), .O_ERR(err_b), .O_MAT(mat_b)
  );
  task automatic pulse(input bit b, input int s);
    if (b) begin vld_b = 1'b1; sel_b = 6'(s); end
    else begin vld_a = 1'b1; sel_a = 6'(s); end
    @(negedge clk);
    vld_a = 1'b0;
    vld_b = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; sel_a = '0; sel_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (rd_a !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_a); end
    checks++; if (addr_a !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", addr_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (ok_a !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", ok_a); end
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_a); end
    checks++; if (nonzero_a() !== 0) begin failures++; $display("FAIL reset_mat nonzero=%0d exp=0", nonzero_a()); end
    checks++; if (ok_b !== 1'b0) begin failures++; $display("FAIL reset_vld_b got=%b exp=0", ok_b); end
    rst = 1'b0;
  endtask
  task automatic test_tile0();
    pulse(0, 0);
    checks++; if (err_a !== 1'b0) begin failures++; $display("FAIL tile0_err got=%b exp=0", err_a); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_a !== 1'b1 || addr_a !== 8'(k)) begin failures++; $display("FAIL tile0_addr k=%0d got rd=%b addr=%0d exp rd=1 addr=%0d", k, rd_a, addr_a, k); end
      @(negedge clk);
    end
    checks++; if (rd_a !== 1'b0) begin failures++; $display("FAIL tile0_rd_off got=%b exp=0", rd_a); end
    @(negedge clk);
    checks++; if (ok_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL tile0_early got vld=%b busy=%b exp vld=0 busy=1", ok_a, busy_a); end
    @(negedge clk);
    checks++; if (ok_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL tile0_done got vld=%b busy=%b exp vld=1 busy=0", ok_a, busy_a); end
    checks++; if (mat_a[5][7] !== 8'd134) begin failures++; $display("FAIL tile0_el57 got=%0d exp=134", mat_a[5][7]); end
    checks++; if (bad_a(0) !== 0) begin failures++; $display("FAIL tile0_mat bad=%0d exp=0", bad_a(0)); end
  endtask
  task automatic test_last_tile();
    pulse(0, 63);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_a !== 1'b1 || addr_a !== 8'(252 + k)) begin failures++; $display("FAIL last_addr k=%0d got rd=%b addr=%0d exp rd=1 addr=%0d", k, rd_a, addr_a, 252 + k); end
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (ok_a !== 1'b0) begin failures++; $display("FAIL last_early got=%b exp=0", ok_a); end
    @(negedge clk);
    checks++; if (ok_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL last_done got vld=%b busy=%b exp vld=1 busy=0", ok_a, busy_a); end
    checks++; if (addr_a !== 8'd255) begin failures++; $display("FAIL last_addr_hold got=%0d exp=255", addr_a); end
    checks++; if (bad_a(63) !== 0) begin failures++; $display("FAIL last_mat bad=%0d exp=0", bad_a(63)); end
  endtask
  task automatic test_back_to_back();
    int n;
    pulse(0, 2);
    checks++; if (addr_a !== 8'd8 || ok_a !== 1'b0) begin failures++; $display("FAIL b2b_first got addr=%0d vld=%b exp addr=8 vld=0", addr_a, ok_a); end
    @(negedge clk);
    pulse(0, 9);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_a !== 1'b1 || addr_a !== 8'(36 + k)) begin failures++; $display("FAIL b2b_addr k=%0d got rd=%b addr=%0d exp rd=1 addr=%0d", k, rd_a, addr_a, 36 + k); end
      if (k < 3) @(negedge clk);
    end
    n = 0;
    for (int y = 0; y < 128; y++) begin
      if (mat_a[0][y] !== exp_el(9, 4, 0, y)) n++;
`ifdef MAT_TILE_LOADER_CLR_EN
      if (mat_a[4][y] !== 8'd0) n++;
`else
      if (mat_a[4][y] !== exp_el(63, 4, 4, y)) n++;
`endif
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL b2b_partial bad=%0d exp=0", n); end
    repeat (2) @(negedge clk);
    checks++; if (ok_a !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", ok_a); end
    @(negedge clk);
    checks++; if (ok_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("FAIL b2b_done got vld=%b busy=%b exp vld=1 busy=0", ok_a, busy_a); end
    checks++; if (bad_a(9) !== 0) begin failures++; $display("FAIL b2b_mat bad=%0d exp=0", bad_a(9)); end
  endtask
  task automatic test_reset_mid();
    pulse(0, 1);
    repeat (4) @(negedge clk);
    checks++; if (busy_a !== 1'b1 || rd_a !== 1'b0) begin failures++; $display("FAIL rstmid_drain got busy=%b rd=%b exp busy=1 rd=0", busy_a, rd_a); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy_a !== 1'b0 || ok_a !== 1'b0 || rd_a !== 1'b0 || err_a !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got busy=%b vld=%b rd=%b err=%b exp all 0", busy_a, ok_a, rd_a, err_a); end
    checks++; if (addr_a !== 8'd0) begin failures++; $display("FAIL rstmid_addr got=%0d exp=0", addr_a); end
    checks++; if (nonzero_a() !== 0) begin failures++; $display("FAIL rstmid_mat nonzero=%0d exp=0", nonzero_a()); end
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || ok_a !== 1'b0) begin failures++; $display("FAIL rstmid_late got busy=%b vld=%b exp 0 0", busy_a, ok_a); end
    checks++; if (nonzero_a() !== 0) begin failures++; $display("FAIL rstmid_late_mat nonzero=%0d exp=0", nonzero_a()); end
  endtask
  task automatic test_rd_lat4();
    pulse(1, 5);
    for (int k = 0; k < 2; k++) begin
      checks++; if (rd_b !== 1'b1 || addr_b !== 8'(10 + k)) begin failures++; $display("FAIL lat4_addr k=%0d got rd=%b addr=%0d exp rd=1 addr=%0d", k, rd_b, addr_b, 10 + k); end
      @(negedge clk);
    end
    checks++; if (rd_b !== 1'b0) begin failures++; $display("FAIL lat4_rd_off got=%b exp=0", rd_b); end
    repeat (3) @(negedge clk);
    checks++; if (ok_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("FAIL lat4_early got vld=%b busy=%b exp vld=0 busy=1", ok_b, busy_b); end
    @(negedge clk);
    checks++; if (ok_b !== 1'b1 || busy_b !== 1'b0) begin failures++; $display("FAIL lat4_done got vld=%b busy=%b exp vld=1 busy=0", ok_b, busy_b); end
    checks++; if (bad_b(5) !== 0) begin failures++; $display("FAIL lat4_mat bad=%0d exp=0", bad_b(5)); end
  endtask
  task automatic test_reject();
    pulse(1, 50);
    checks++; if (err_b !== 1'b1 || rd_b !== 1'b0 || ok_b !== 1'b1) begin failures++; $display("FAIL reject_pulse got err=%b rd=%b vld=%b exp err=1 rd=0 vld=1", err_b, rd_b, ok_b); end
    @(negedge clk);
    checks++; if (err_b !== 1'b0 || rd_b !== 1'b0 || busy_b !== 1'b0 || ok_b !== 1'b1) begin failures++; $display("FAIL reject_after got err=%b rd=%b busy=%b vld=%b exp 0 0 0 1", err_b, rd_b, busy_b, ok_b); end
    checks++; if (bad_b(5) !== 0) begin failures++; $display("FAIL reject_mat bad=%0d exp=0", bad_b(5)); end
  endtask
  initial begin
    test_reset();
    test_tile0();
    test_last_tile();
    test_back_to_back();
    test_reset_mid();
    test_rd_lat4();
    test_reject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mat_tile_loader.md
# mat_tile_loader

Parametrised successor of the fixed Q-matrix loader. On a start pulse it fetches one tile of TILE_ROWS×COLS elements from an external synchronous-read ROM/BRAM (ROWS_PER_WORD rows packed per memory word), unpacks the words into a registered 2-D output matrix and raises a valid flag when the tile is complete. It sits between the Q/K/V weight/activation memories and the MHA compute array, and supports restart mid-fetch and range checking of the tile select.

## Interface
- DATA_W, 8, element width in bits
- COLS, 128, elements per matrix row
- ROWS_PER_WORD, 4, rows packed in one memory word (word width = ROWS_PER_WORD*COLS*DATA_W)
- TILE_ROWS, 16, rows per output tile; must be a multiple of ROWS_PER_WORD (WPT = TILE_ROWS/ROWS_PER_WORD words per tile)
- NUM_TILES, 64, number of selectable tiles; SEL_W = $clog2(NUM_TILES)
- ADDR_W, 8, memory address width; NUM_TILES*WPT <= 2**ADDR_W
- RD_LAT, 2, memory read latency in cycles (>= 1)
- I_CLK  in  1  clock, all logic on rising edge
- I_RST  in  1  reset, synchronous, active-high
- I_VLD_PULSE  in  1  start request, sampled every cycle
- I_SEL  in  SEL_W  tile index, sampled with I_VLD_PULSE
- O_RD_EN  out  1  memory read enable
- O_ADDR  out  ADDR_W  memory address
- I_RDATA  in  ROWS_PER_WORD*COLS*DATA_W  memory read data
- O_BUSY  out  1  fetch in progress
- O_VLD  out  1  tile complete, level
- O_ERR  out  1  one-cycle pulse: request rejected (I_SEL >= NUM_TILES)
- O_MAT  out  [0:TILE_ROWS-1][0:COLS-1] of DATA_W  assembled tile

## Operation
- States: S_IDLE, S_ISSUE, S_DRAIN, S_DONE.
- Accept: I_VLD_PULSE=1 with I_SEL < NUM_TILES, in any state → S_ISSUE, base = I_SEL*WPT, issue counter 0, O_VLD<=0, O_BUSY<=1, in-flight read tags cleared (restart aborts previous fetch; returns of the aborted fetch are never written).
- Reject: I_VLD_PULSE=1 with I_SEL >= NUM_TILES → O_ERR pulses one cycle; state, O_VLD, O_MAT unchanged.
- S_ISSUE: O_RD_EN=1, O_ADDR = base + k for k = 0..WPT-1 on consecutive cycles; after k = WPT-1 → S_DRAIN.
- Return pipe: RD_LAT-deep valid/word-index shift register; when a tag emerges, word k is unpacked: O_MAT[k*ROWS_PER_WORD + x][y] <= I_RDATA[(x*COLS + y)*DATA_W +: DATA_W], x in 0..ROWS_PER_WORD-1, y in 0..COLS-1.
- S_DRAIN: when the tag of word WPT-1 emerges → S_DONE, O_VLD<=1, O_BUSY<=0 at the same edge as the last row write.
- S_DONE: O_VLD held until next accepted pulse or reset; returns to S_ISSUE on accept. S_IDLE only after reset.
- O_MAT rows not yet rewritten by the current fetch retain prior contents (see Configuration).

## Timing
- Reset (I_RST=1 at edge): state S_IDLE, O_VLD=0, O_BUSY=0, O_ERR=0, O_RD_EN=0, O_ADDR=0, O_MAT all zero, tags cleared. Reset dominates I_VLD_PULSE.
- Accept at edge E0; O_RD_EN/O_ADDR valid in the cycles following edges E0..E(WPT-1); memory samples read k at E(k+1); block captures word k at E(k+1+RD_LAT).
- O_VLD rises after edge E(WPT+RD_LAT); defaults: E6, i.e. visible 6 cycles after the accepting edge.
- Back-to-back pulses: each accept restarts from k=0; only the last accepted select completes.
- O_ADDR never exceeds NUM_TILES*WPT-1; no wrap-around.

## Configuration
- MAT_TILE_LOADER_CLR_EN defined: on every accepted request all of O_MAT is cleared to zero at the accepting edge, so partially loaded tiles never expose stale data.
- Not defined: O_MAT is only written by returning words; stale rows persist until overwritten.

## Structure
- Package mat_pkg: state enum type, default DATA_W/COLS constants, helper function computing WPT and SEL_W.
- Sub-module mat_rd_lat_pipe: RD_LAT-deep valid + word-index shift register with synchronous flush; the unpack/write logic stays in the top.

## Test plan
- Reset then pulse I_SEL=0, memory word i = pattern with byte (x*128+y)^i → addresses 0,1,2,3 on consecutive cycles, O_VLD rises 6 cycles after accept, O_MAT[5][7] = word1 byte (1*128+7)^1.
- I_SEL=63 → addresses 252..255, O_VLD after 6 cycles, O_BUSY low with O_VLD.
- Pulse I_SEL=2, second pulse I_SEL=9 two cycles later → addresses restart at 36; O_VLD 6 cycles after second pulse; no row contains tile-2 data (with CLR_EN) .
- NUM_TILES=48, pulse I_SEL=50 → O_ERR one cycle, no O_RD_EN, O_VLD/O_MAT unchanged.
- I_RST asserted mid-S_DRAIN → next cycle all outputs at reset values, later returning data ignored.
- RD_LAT=4, TILE_ROWS=8 → 2 reads, O_VLD after 6 cycles, rows 0..7 correct.
